// File: rtl/cordiv_mc_kernel.sv
// Multi-channel correlated stochastic divider (CORDIV) with per-channel
// windowed ones-counters; tap selection comes from a shared internal LFSR.
module cordiv_mc_kernel #(
  parameter int         CH     = 4,
  parameter int         DEPLOG = 2,
  parameter int         DEP    = 4,
  parameter int         WIN    = 8,
  parameter logic [7:0] SEED   = 8'h5A
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [CH-1:0]          dividend,
  input  logic [CH-1:0]          divisor,
  output logic [CH-1:0]          quotient,
  output logic [CH*(WIN+1)-1:0]  cnt,
  output logic                   cnt_vld
);

  localparam int CW = WIN + 1;

  // History reset pattern: bit i holds i%2.
  function automatic logic [DEP-1:0] alt_pattern();
    logic [DEP-1:0] p;
    for (int i = 0; i < DEP; i++) begin
      p[i] = ((i % 2) == 1);
    end
    return p;
  endfunction

  localparam logic [DEP-1:0] SR_INIT = alt_pattern();

  logic [7:0]        lfsr_reg;
  logic [7:0]        lfsr_next;
  logic [WIN-1:0]    wcnt_reg;
  logic [DEPLOG-1:0] idx;
  logic              advance;
  logic              win_end;

  assign idx       = lfsr_reg[DEPLOG-1:0];
  assign advance   = en & ~clr;
  assign win_end   = advance & (wcnt_reg == {WIN{1'b1}});
  // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else if (advance) begin
      lfsr_reg <= lfsr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_reg <= '0;
    end else if (clr) begin
      wcnt_reg <= '0;
    end else if (en) begin
      wcnt_reg <= wcnt_reg + WIN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_vld <= 1'b0;
    end else begin
      cnt_vld <= win_end;
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [DEP-1:0] sr_reg;
      logic [WIN:0]   acc_reg;
      logic [WIN:0]   acc_sum;
      logic [WIN:0]   cnt_reg;

      assign quotient[gi]      = divisor[gi] ? dividend[gi] : sr_reg[idx];
      assign acc_sum           = acc_reg + CW'(quotient[gi]);
      assign cnt[gi*CW +: CW]  = cnt_reg;

      // clr restarts the window but leaves history and last result alone.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr_reg  <= SR_INIT;
          acc_reg <= '0;
          cnt_reg <= '0;
        end else if (clr) begin
          acc_reg <= '0;
        end else if (en) begin
          sr_reg <= {quotient[gi], sr_reg[DEP-1:1]};
          if (win_end) begin
            cnt_reg <= acc_sum;
            acc_reg <= '0;
          end else begin
            acc_reg <= acc_sum;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cordiv_mc_kernel.sv
// Randomized bench for cordiv_mc_kernel: a queue-based behavioural model is
// checked every cycle, plus hand-computed expectations for the directed cases.
module tb_cordiv_mc_kernel;

  localparam int         CH     = 4;
  localparam int         DEPLOG = 2;
  localparam int         DEP    = 4;
  localparam int         WIN    = 8;
  localparam logic [7:0] SEED   = 8'h5A;
  localparam int         CW     = WIN + 1;
  localparam int         WLEN   = 1 << WIN;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 clr;
  logic [CH-1:0]        dividend;
  logic [CH-1:0]        divisor;
  logic [CH-1:0]        quotient;
  logic [CH*CW-1:0]     cnt;
  logic                 cnt_vld;

  cordiv_mc_kernel #(
    .CH(CH), .DEPLOG(DEPLOG), .DEP(DEP), .WIN(WIN), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .cnt(cnt), .cnt_vld(cnt_vld)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: newest history bit at the back of each queue.
  bit hist [CH][$];
  int m_lfsr;
  int m_pos;
  int m_ones [CH];
  int m_cnt  [CH];
  bit m_vld;

  // Samples taken at the last compare point.
  logic [CH-1:0] s_q;
  logic          s_vld;
  int            s_cnt [CH];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      hist[c].delete();
      for (int i = 0; i < DEP; i++) hist[c].push_back(bit'(i % 2));
      m_ones[c] = 0;
      m_cnt[c]  = 0;
    end
    m_lfsr = SEED;
    m_pos  = 0;
    m_vld  = 1'b0;
  endfunction

  task automatic compare_and_advance();
    bit q [CH];
    int idx;
    int fb;
    if (rst) model_reset();
    idx = m_lfsr % DEP;
    for (int c = 0; c < CH; c++) begin
      q[c] = divisor[c] ? dividend[c] : hist[c][idx];
      s_q[c]   = quotient[c];
      s_cnt[c] = int'(cnt[c*CW +: CW]);
      check($sformatf("quotient[%0d]", c), int'(quotient[c]), int'(q[c]));
      check($sformatf("cnt[%0d]", c), s_cnt[c], m_cnt[c]);
    end
    s_vld = cnt_vld;
    check("cnt_vld", int'(cnt_vld), int'(m_vld));
    if (!rst) begin
      if (clr) begin
        m_pos = 0;
        m_vld = 1'b0;
        for (int c = 0; c < CH; c++) m_ones[c] = 0;
      end else if (en) begin
        for (int c = 0; c < CH; c++) begin
          void'(hist[c].pop_front());
          hist[c].push_back(q[c]);
          m_ones[c] += int'(q[c]);
        end
        fb     = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 8'hFF;
        if (m_pos == WLEN - 1) begin
          for (int c = 0; c < CH; c++) begin
            m_cnt[c]  = m_ones[c];
            m_ones[c] = 0;
          end
          m_vld = 1'b1;
          m_pos = 0;
        end else begin
          m_pos++;
          m_vld = 1'b0;
        end
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  // Inputs change just after a rising edge; outputs are compared at the falling edge.
  task automatic step(input bit e, input bit c, input logic [CH-1:0] dv, input logic [CH-1:0] dd);
    en = e; clr = c; divisor = dv; dividend = dd;
    @(negedge clk);
    compare_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_step(input bit e, input bit c);
    logic [CH-1:0] dv;
    logic [CH-1:0] dd;
    dv = CH'($urandom);
    dd = dv & CH'($urandom);
    step(e, c, dv, dd);
  endtask

  // Asserts rst between edges; idle channels show the reset history tap (idx=2 -> 0).
  task automatic do_reset();
    rst = 1'b1;
    #2;
    step(1'b1, 1'b0, '0, '0);
    check("rst cnt_vld", int'(s_vld), 0);
    check("rst quotient", int'(s_q), 0);
    for (int c = 0; c < CH; c++) check($sformatf("rst cnt[%0d]", c), s_cnt[c], 0);
    step(1'b1, 1'b0, '0, '0);
    rst = 1'b0;
  endtask

  initial begin
    int sum;
    int wins;
    int en_cnt;
    int at;
    bit found;
    logic dv0;
    logic dd0;

    rst = 1'b1; en = 1'b0; clr = 1'b0; divisor = '0; dividend = '0;
    #1;
    do_reset();

    // All-ones division: every bit is 1, first pulse after 256 enabled cycles.
    repeat (WLEN) step(1'b1, 1'b0, '1, '1);
    step(1'b0, 1'b0, '1, '1);
    check("t1 cnt_vld", int'(s_vld), 1);
    check("t1 quotient", int'(s_q), 15);
    for (int c = 0; c < CH; c++) check($sformatf("t1 cnt[%0d]", c), s_cnt[c], 256);

    // Zero dividend: count 0, then history-only quotient is 0.
    repeat (WLEN) step(1'b1, 1'b0, '1, '0);
    step(1'b0, 1'b0, '1, '0);
    check("t2 cnt_vld", int'(s_vld), 1);
    for (int c = 0; c < CH; c++) check($sformatf("t2 cnt[%0d]", c), s_cnt[c], 0);
    step(1'b0, 1'b0, '0, '0);
    check("t2 quotient", int'(s_q), 0);
    check("t2 cnt_vld drop", int'(s_vld), 0);

    // Ratio 0.5 on ch0, other channels idle.
    sum = 0; wins = 0;
    for (int i = 0; i <= 8 * WLEN; i++) begin
      dv0 = 1'($urandom);
      dd0 = dv0 & 1'($urandom);
      step(i < 8 * WLEN, 1'b0, {3'b000, dv0}, {3'b000, dd0});
      if (s_vld) begin
        wins++;
        sum += s_cnt[0];
        for (int c = 1; c < CH; c++) check($sformatf("t3 idle cnt[%0d]", c), s_cnt[c], 0);
      end
    end
    check("t3 windows", wins, 8);
    check("t3 ch0 mean in 108..148", int'((sum >= 108 * 8) && (sum <= 148 * 8)), 1);

    // en toggling: pulse needs 256 enabled cycles, seen on clock 511 after start.
    do_reset();
    found = 1'b0; en_cnt = 0; at = -1;
    for (int k = 0; k < 1200 && !found; k++) begin
      rand_step(k % 2 == 0, 1'b0);
      if (s_vld) begin
        found = 1'b1;
        at = k;
      end else if (k % 2 == 0) begin
        en_cnt++;
      end
    end
    check("t4 pulse seen", int'(found), 1);
    check("t4 pulse clock", at, 511);
    check("t4 enabled cycles", en_cnt, 256);

    // clr mid-window: no pulse, old result holds, new window restarts at clr.
    do_reset();
    repeat (WLEN) step(1'b1, 1'b0, '1, '1);
    repeat (100) rand_step(1'b1, 1'b0);
    rand_step(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < WLEN; i++) begin
      rand_step(1'b1, 1'b0);
      if (s_vld) found = 1'b1;
    end
    check("t5 no early pulse", int'(found), 0);
    for (int c = 0; c < CH; c++) check($sformatf("t5 held cnt[%0d]", c), s_cnt[c], 256);
    step(1'b0, 1'b0, '0, '0);
    check("t5 pulse after clr", int'(s_vld), 1);
    repeat (WLEN - 1) rand_step(1'b1, 1'b0);
    rand_step(1'b1, 1'b1);
    step(1'b0, 1'b0, '0, '0);
    check("t5 clr at window end", int'(s_vld), 0);

    // Async reset mid-window, then a clean restart.
    do_reset();
    repeat (WLEN) step(1'b1, 1'b0, '1, '1);
    repeat (50) rand_step(1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b0, '0, '0);
    check("t6 tap 0", int'(s_q), 0);
    step(1'b1, 1'b0, '0, '0);
    check("t6 tap 1", int'(s_q), 15);
    step(1'b1, 1'b0, '0, '0);
    check("t6 tap 2", int'(s_q), 15);
    found = 1'b0;
    for (int i = 0; i < WLEN - 3; i++) begin
      rand_step(1'b1, 1'b0);
      if (s_vld) found = 1'b1;
    end
    check("t6 no early pulse", int'(found), 0);
    step(1'b0, 1'b0, '0, '0);
    check("t6 first pulse", int'(s_vld), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
